// File: rtl/muldiv_pkg.sv
// Shared types and sign helpers for the iterative multiply/divide unit.
//   muldiv_op_t : operation encoding carried on op_e
//   state_t     : sequencer states
//   neg_w/abs_w : two's-complement negate / conditional negate on a wide
//                 vector; callers zero-extend and truncate to their width,
//                 which is exact because the low bits of a negation depend
//                 only on the low bits of its operand.
package muldiv_pkg;

  localparam int unsigned MD_MAX_W = 64;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [MD_MAX_W-1:0] neg_w(input logic [MD_MAX_W-1:0] x);
    return ~x + MD_MAX_W'(1);
  endfunction

  function automatic logic [MD_MAX_W-1:0] abs_w(input logic [MD_MAX_W-1:0] x,
                                                input logic                is_neg);
    return is_neg ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the Execute stage; owns HI/LO.
// Ports:
//   clk_i, reset_ni        clock, async active-low reset
//   start_e, op_e          launch MULT/MULTU/DIV/DIVU (ignored while busy)
//   rs_e, rt_e             operand A (dividend), operand B (divisor)
//   mthi_e, mtlo_e         write rs_e to HI/LO when idle and not starting
//   flush_i                abort an in-flight op, or suppress a start
//   busy_o                 registered, high while the sequencer is not idle
//   done_o                 registered, high for the single S_FIX cycle
//   hi_o, lo_o             architectural HI/LO
// WIDTH must be even, >= 4 and <= 32 (2*WIDTH must fit the helper width).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] rs_e,
  input  logic [WIDTH-1:0] rt_e,
  input  logic             mthi_e,
  input  logic             mtlo_e,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t              r_state;
  state_t              w_state_n;
  logic [CNT_W-1:0]    r_cnt;
  logic [W2-1:0]       r_acc;     // mult: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]    r_b;       // |multiplicand| or |divisor|
  logic                r_is_div;
  logic                r_neg_q;   // negate product / quotient
  logic                r_neg_r;   // negate remainder (dividend sign)
  logic                r_div0;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_busy;
  logic                r_done;

  muldiv_op_t          w_op;
  logic                w_signed;
  logic                w_sa;
  logic                w_sb;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic                w_launch;

  logic [WIDTH:0]      w_mul_sum;
  logic [WIDTH:0]      w_div_cand;
  logic                w_div_ge;
  logic [WIDTH-1:0]    w_div_diff;
  logic [W2-1:0]       w_acc_step;

  logic [W2-1:0]       w_prod_fix;
  logic [WIDTH-1:0]    w_quot_fix;
  logic [WIDTH-1:0]    w_rem_fix;
  logic [WIDTH-1:0]    w_hi_fix;
  logic [WIDTH-1:0]    w_lo_fix;

  // Operand conditioning at launch.
  always_comb begin
    w_op     = muldiv_op_t'(op_e);
    w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    w_sa     = w_signed & rs_e[WIDTH-1];
    w_sb     = w_signed & rt_e[WIDTH-1];
    w_abs_a  = WIDTH'(abs_w(MD_MAX_W'(rs_e), w_sa));
    w_abs_b  = WIDTH'(abs_w(MD_MAX_W'(rt_e), w_sb));
    w_launch = start_e && !flush_i;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_div_cand = r_acc[W2-1:WIDTH-1];
    w_div_ge   = (w_div_cand >= {1'b0, r_b});
    w_div_diff = WIDTH'(w_div_cand - {1'b0, r_b});
    if (r_is_div) begin
      w_acc_step = {(w_div_ge ? w_div_diff : w_div_cand[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_div_ge};
    end else begin
      w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign correction applied during S_FIX. A zero divisor leaves rem=|A|, so
  // restoring the dividend sign yields rs_e unchanged; only LO needs forcing.
  always_comb begin
    w_prod_fix = W2'(abs_w(MD_MAX_W'(r_acc), r_neg_q));
    w_quot_fix = WIDTH'(abs_w(MD_MAX_W'(r_acc[WIDTH-1:0]), r_neg_q));
    w_rem_fix  = WIDTH'(abs_w(MD_MAX_W'(r_acc[W2-1:WIDTH]), r_neg_r));
    if (r_is_div) begin
      w_hi_fix = w_rem_fix;
      w_lo_fix = r_div0 ? '1 : w_quot_fix;
    end else begin
      w_hi_fix = w_prod_fix[W2-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_state_n = S_CALC;
      S_CALC: begin
        if (flush_i)              w_state_n = S_IDLE;
        else if (r_cnt == '0)     w_state_n = S_FIX;
      end
      S_FIX:                      w_state_n = S_IDLE;
      default:                    w_state_n = S_IDLE;
    endcase
  end

  // Sequencer, datapath and architectural HI/LO.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != S_IDLE);
      r_done  <= (w_state_n == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start_e) begin
            // A start always drops a same-cycle MT write, even if flushed.
            if (!flush_i) begin
              r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
              r_b      <= w_abs_b;
              r_is_div <= op_e[1];
              r_neg_q  <= w_sa ^ w_sb;
              r_neg_r  <= w_sa;
              r_div0   <= op_e[1] && (rt_e == '0);
              r_cnt    <= CNT_W'(WIDTH - 1);
            end
          end else begin
            if (mthi_e) r_hi <= rs_e;
            if (mtlo_e) r_lo <= rs_e;
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec vectors, randomized
// ops against an arithmetic reference, MT writes, flush and async reset.
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic         start_e;
  logic [1:0]   op_e;
  logic [W-1:0] rs_e;
  logic [W-1:0] rt_e;
  logic         mthi_e;
  logic         mtlo_e;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural HI/LO as the bench believes them to be.
  logic [W-1:0] cur_hi;
  logic [W-1:0] cur_lo;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .start_e (start_e),
    .op_e    (op_e),
    .rs_e    (rs_e),
    .rt_e    (rt_e),
    .mthi_e  (mthi_e),
    .mtlo_e  (mtlo_e),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain 64-bit arithmetic following the result rules.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: begin p = longint'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = ua * ub;           hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end else begin
          p = ua / ub; hi = p[31:0];
          p = ua % ub; lo = hi; hi = p[31:0]; lo = W'(ua / ub);
        end
      end
    endcase
  endtask

  // Launch one op and follow it until busy_o drops; optionally pulse mtlo_e
  // or flush_i once busy has been seen for a given number of cycles.
  task automatic drive_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mt_at, input int flush_at,
                          output int busy_cyc, output int done_cyc, output bit timeout);
    @(negedge clk_i);
    start_e = 1'b1; op_e = op; rs_e = a; rt_e = b;
    @(posedge clk_i); #1;
    start_e = 1'b0;
    busy_cyc = 0; done_cyc = 0; timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin timeout = 1'b0; break; end
      busy_cyc++;
      if (done_o) done_cyc++;
      if (busy_cyc == mt_at) begin mtlo_e = 1'b1; rs_e = 32'h0BAD_F00D; end
      if (busy_cyc == flush_at) flush_i = 1'b1;
      @(posedge clk_i); #1;
      mtlo_e = 1'b0; flush_i = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_ni = 1'b0; start_e = 1'b0; op_e = '0; rs_e = '0; rt_e = '0;
    mthi_e = 1'b0; mtlo_e = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done got %0b want 0", done_o); else n_pass++;
    n_checks++; if (hi_o !== '0) $display("FAIL reset_hi got %h want 0", hi_o); else n_pass++;
    n_checks++; if (lo_o !== '0) $display("FAIL reset_lo got %h want 0", lo_o); else n_pass++;
    reset_ni = 1'b1;
    cur_hi = '0; cur_lo = '0;
  endtask

  // Full op with latency, done-pulse and result checks.
  task automatic check_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    int bc, dc; bit to;
    logic [W-1:0] eh, el;
    model(op, a, b, eh, el);
    drive_op(op, a, b, -1, -1, bc, dc, to);
    n_checks++; if (to) $display("FAIL %s_timeout busy stuck high", name); else n_pass++;
    n_checks++; if (bc != W + 1) $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, W + 1); else n_pass++;
    n_checks++; if (dc != 1) $display("FAIL %s_done_pulses got %0d want 1", name, dc); else n_pass++;
    n_checks++; if (hi_o !== eh) $display("FAIL %s_hi got %h want %h (op %0d a %h b %h)", name, hi_o, eh, op, a, b); else n_pass++;
    n_checks++; if (lo_o !== el) $display("FAIL %s_lo got %h want %h (op %0d a %h b %h)", name, lo_o, el, op, a, b); else n_pass++;
    cur_hi = eh; cur_lo = el;
  endtask

  task automatic test_directed;
    check_op("mult_neg3x7",  2'd0, 32'hFFFF_FFFD, 32'd7);
    check_op("multu_max",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("div_m7_2",     2'd2, 32'hFFFF_FFF9, 32'd2);
    check_op("divu_7_2",     2'd3, 32'd7, 32'd2);
    check_op("div_intmin_m1",2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("divu_by0",     2'd3, 32'h1234_5678, 32'd0);
    check_op("div_by0_neg",  2'd2, 32'h8765_4321, 32'd0);
  endtask

  task automatic test_random;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 9)) - W'(4);
      if ($urandom_range(0, 7) == 0) b = '0;
      check_op("rand", op, a, b);
    end
  endtask

  task automatic test_mt;
    int bc, dc; bit to;
    logic [W-1:0] eh, el;
    @(negedge clk_i);
    mthi_e = 1'b1; rs_e = 32'hAAAA_5555;
    @(posedge clk_i); #1; mthi_e = 1'b0;
    n_checks++; if (hi_o !== 32'hAAAA_5555) $display("FAIL mthi_idle got %h want aaaa5555", hi_o); else n_pass++;
    n_checks++; if (lo_o !== cur_lo) $display("FAIL mthi_lo_kept got %h want %h", lo_o, cur_lo); else n_pass++;
    @(negedge clk_i);
    mtlo_e = 1'b1; rs_e = 32'h1357_9BDF;
    @(posedge clk_i); #1; mtlo_e = 1'b0;
    n_checks++; if (lo_o !== 32'h1357_9BDF) $display("FAIL mtlo_idle got %h want 13579bdf", lo_o); else n_pass++;
    // MTLO while busy must not disturb the pending result.
    model(2'd1, 32'h0001_2345, 32'h0006_789A, eh, el);
    drive_op(2'd1, 32'h0001_2345, 32'h0006_789A, 5, -1, bc, dc, to);
    n_checks++; if (to || bc != W + 1) $display("FAIL mtlo_busy_cycles got %0d want %0d", bc, W + 1); else n_pass++;
    n_checks++; if (lo_o !== el) $display("FAIL mtlo_busy_lo got %h want %h", lo_o, el); else n_pass++;
    n_checks++; if (hi_o !== eh) $display("FAIL mtlo_busy_hi got %h want %h", hi_o, eh); else n_pass++;
    cur_hi = eh; cur_lo = el;
  endtask

  task automatic test_flush;
    int bc, dc; bit to;
    drive_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, -1, 10, bc, dc, to);
    n_checks++; if (to || bc != 10) $display("FAIL flush_busy_cycles got %0d want 10", bc); else n_pass++;
    n_checks++; if (dc != 0) $display("FAIL flush_done got %0d want 0", dc); else n_pass++;
    n_checks++; if (hi_o !== cur_hi) $display("FAIL flush_hi got %h want %h", hi_o, cur_hi); else n_pass++;
    n_checks++; if (lo_o !== cur_lo) $display("FAIL flush_lo got %h want %h", lo_o, cur_lo); else n_pass++;
    // Flush in the same cycle as a start suppresses the launch.
    @(negedge clk_i);
    start_e = 1'b1; flush_i = 1'b1; op_e = 2'd3; rs_e = 32'd9; rt_e = 32'd2;
    @(posedge clk_i); #1; start_e = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_start_busy got %0b want 0", busy_o); else n_pass++;
    // The unit must still work after an abort.
    check_op("after_flush", 2'd2, 32'd100, 32'hFFFF_FFF9);
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    start_e = 1'b1; op_e = 2'd2; rs_e = 32'h7FFF_0001; rt_e = 32'd3;
    @(posedge clk_i); #1; start_e = 1'b0;
    repeat (6) @(posedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL rstmid_done got %0b want 0", done_o); else n_pass++;
    n_checks++; if (hi_o !== '0) $display("FAIL rstmid_hi got %h want 0", hi_o); else n_pass++;
    n_checks++; if (lo_o !== '0) $display("FAIL rstmid_lo got %h want 0", lo_o); else n_pass++;
    @(negedge clk_i); reset_ni = 1'b1;
    cur_hi = '0; cur_lo = '0;
    check_op("after_reset", 2'd3, 32'hFFFF_FFF0, 32'd16);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mt();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
